// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Holds the FSM state encoding and the per-stage control bundle.
package pipeline_stall_ctrl_pkg;

    localparam int DEFAULT_CNT_W    = 32;
    localparam int DEFAULT_MAX_WAIT = 255;
    localparam int DEFAULT_WAIT_W   = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } stallState_e;

    typedef struct packed {
        logic pcWrite;
        logic ifidWrite;
        logic ifidFlush;
        logic idexWrite;
        logic idexFlush;
        logic exmemWrite;
        logic memwbWrite;
    } stageCtrl_t;

    // Every latch advances, nothing is cleared.
    localparam stageCtrl_t CTRL_RUN = '{
        pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b0, idexWrite: 1'b1,
        idexFlush: 1'b0, exmemWrite: 1'b1, memwbWrite: 1'b1
    };

    localparam stageCtrl_t CTRL_HOLD = '{
        pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0, idexWrite: 1'b0,
        idexFlush: 1'b0, exmemWrite: 1'b0, memwbWrite: 1'b0
    };

    // During reset the front latches are cleared so the pipe restarts empty.
    localparam stageCtrl_t CTRL_RESET = '{
        pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b1, idexWrite: 1'b0,
        idexFlush: 1'b1, exmemWrite: 1'b0, memwbWrite: 1'b0
    };

endpackage

// File: rtl/pipeline_stall_ctrl_perf_counter.sv
// Free-running event counter: synchronous clear, +1 per enabled cycle,
// wraps modulo 2^CNT_W.
module pipeline_stall_ctrl_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_o <= '0;
        end else if (inc_i) begin
            count_o <= count_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Resolves memory freeze, load-use hazard and branch flush requests into
// per-stage write/flush controls, with perf counters and a memory watchdog.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int WAIT_W   = DEFAULT_WAIT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             noOpSignal_i,
    input  logic             stallSignal_i,
    input  logic             PCWriteSignal_i,
    input  logic             branchFlush_i,
    input  logic             memReq_i,
    input  logic             memAck_i,
    output logic             pcWrite_o,
    output logic             ifidWrite_o,
    output logic             ifidFlush_o,
    output logic             idexWrite_o,
    output logic             idexFlush_o,
    output logic             exmemWrite_o,
    output logic             memwbWrite_o,
    output logic [CNT_W-1:0] loadStallCnt_o,
    output logic [CNT_W-1:0] memStallCnt_o,
    output logic [CNT_W-1:0] flushCnt_o,
    output logic             timeout_o,
    output logic [1:0]       dbgState_o
);

    // Memory handshake: memReq_i is a level held by the EX/MEM instruction
    // until the cycle memAck_i is high; that ack cycle completes the access
    // and is not frozen. Req+ack in one cycle is a single-cycle access.

    stallState_e       state, nextState;
    logic [WAIT_W-1:0] waitCnt, nextWait, stepWait;
    logic              timeoutQ, nextTimeout;
    stageCtrl_t        ctrl;
    logic              freeze, loadUse;
    logic              frozenCycle, loadCycle, flushCycle;

    assign freeze  = memReq_i && !memAck_i;
    assign loadUse = noOpSignal_i || stallSignal_i || !PCWriteSignal_i;

    always_comb begin
        ctrl        = CTRL_RUN;
        nextState   = state;
        nextWait    = waitCnt;
        stepWait    = '0;
        nextTimeout = timeoutQ;
        frozenCycle = 1'b0;
        loadCycle   = 1'b0;

        case (state)
            RUN, MEM_WAIT: begin
                if (freeze) begin
                    ctrl        = CTRL_HOLD;
                    frozenCycle = 1'b1;
                    stepWait    = (state == RUN) ? WAIT_W'(1) : waitCnt + WAIT_W'(1);
                    nextWait    = stepWait;
                    if (stepWait == WAIT_W'(MAX_WAIT)) begin
                        nextState   = ERROR;
                        nextTimeout = 1'b1;
                    end else begin
                        nextState = MEM_WAIT;
                    end
                end else begin
                    // Ack or dropped request both end any wait in progress.
                    nextState = RUN;
                    nextWait  = '0;
                    if (loadUse) begin
                        loadCycle      = 1'b1;
                        ctrl.pcWrite   = PCWriteSignal_i;
                        ctrl.ifidWrite = !stallSignal_i;
                        ctrl.idexFlush = noOpSignal_i;
                    end else if (branchFlush_i) begin
                        ctrl.ifidFlush = 1'b1;
                    end
                end
            end
            default: begin
                ctrl = CTRL_HOLD;
            end
        endcase

        if (rst_i) begin
            ctrl        = CTRL_RESET;
            frozenCycle = 1'b0;
            loadCycle   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            waitCnt  <= '0;
            timeoutQ <= 1'b0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextWait;
            timeoutQ <= nextTimeout;
        end
    end

    assign flushCycle = ctrl.ifidFlush && !rst_i;

    pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) perfLoadStall (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (loadCycle),
        .count_o (loadStallCnt_o)
    );

    pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) perfMemStall (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (frozenCycle),
        .count_o (memStallCnt_o)
    );

    pipeline_stall_ctrl_perf_counter #(.CNT_W(CNT_W)) perfFlush (
        .clk_i   (clk_i),
        .clear_i (rst_i),
        .inc_i   (flushCycle),
        .count_o (flushCnt_o)
    );

    assign pcWrite_o    = ctrl.pcWrite;
    assign ifidWrite_o  = ctrl.ifidWrite;
    assign ifidFlush_o  = ctrl.ifidFlush;
    assign idexWrite_o  = ctrl.idexWrite;
    assign idexFlush_o  = ctrl.idexFlush;
    assign exmemWrite_o = ctrl.exmemWrite;
    assign memwbWrite_o = ctrl.memwbWrite;
    assign timeout_o    = timeoutQ;
    assign dbgState_o   = state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: small counters and a short
// watchdog so wrap and timeout behaviour are reachable quickly.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 3;

    // Control vector order: pcWrite ifidWrite ifidFlush idexWrite idexFlush exmemWrite memwbWrite
    localparam logic [6:0] EXP_RESET  = 7'b0010100;
    localparam logic [6:0] EXP_RUN    = 7'b1101011;
    localparam logic [6:0] EXP_HOLD   = 7'b0000000;
    localparam logic [6:0] EXP_BRANCH = 7'b1111011;
    localparam logic [6:0] EXP_LOAD   = 7'b0001111;
    localparam logic [6:0] EXP_NOOP   = 7'b1101111;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic noOp = 1'b0, stall = 1'b0, pcw = 1'b1, br = 1'b0, req = 1'b0, ack = 1'b0;

    logic             pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite, memwbWrite;
    logic [CNT_W-1:0] loadStallCnt, memStallCnt, flushCnt;
    logic             timeout;
    logic [1:0]       dbgState;
    logic [6:0]       ctrlVec;

    int checkCnt = 0;
    int passCnt  = 0;

    assign ctrlVec = {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite, memwbWrite};

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .noOpSignal_i    (noOp),
        .stallSignal_i   (stall),
        .PCWriteSignal_i (pcw),
        .branchFlush_i   (br),
        .memReq_i        (req),
        .memAck_i        (ack),
        .pcWrite_o       (pcWrite),
        .ifidWrite_o     (ifidWrite),
        .ifidFlush_o     (ifidFlush),
        .idexWrite_o     (idexWrite),
        .idexFlush_o     (idexFlush),
        .exmemWrite_o    (exmemWrite),
        .memwbWrite_o    (memwbWrite),
        .loadStallCnt_o  (loadStallCnt),
        .memStallCnt_o   (memStallCnt),
        .flushCnt_o      (flushCnt),
        .timeout_o       (timeout),
        .dbgState_o      (dbgState)
    );

    task automatic setIn(input logic n, input logic s, input logic p,
                         input logic b, input logic r, input logic a);
        noOp  = n;
        stall = s;
        pcw   = p;
        br    = b;
        req   = r;
        ack   = a;
    endtask

    task automatic setIdle();
        setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        setIdle();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkCnt++;
            if (ctrlVec !== EXP_RESET)
                $display("FAIL reset_ctrl[%0d]: got %b want %b", i, ctrlVec, EXP_RESET);
            else passCnt++;
            step();
        end
        rst = 1'b0;
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_RUN) $display("FAIL release_ctrl: got %b want %b", ctrlVec, EXP_RUN);
        else passCnt++;
        checkCnt++;
        if ({loadStallCnt, memStallCnt, flushCnt} !== '0)
            $display("FAIL release_counters: got %0d/%0d/%0d want 0/0/0", loadStallCnt, memStallCnt, flushCnt);
        else passCnt++;
        checkCnt++;
        if (timeout !== 1'b0 || dbgState !== ST_RUN)
            $display("FAIL release_state: got timeout=%b state=%0d want 0/%0d", timeout, dbgState, ST_RUN);
        else passCnt++;
        step();
    endtask

    task automatic test_load_use();
        setIn(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_LOAD) $display("FAIL load_use_ctrl: got %b want %b", ctrlVec, EXP_LOAD);
        else passCnt++;
        step();
        setIn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkCnt++;
        if (loadStallCnt !== 4'd1 || flushCnt !== 4'd0)
            $display("FAIL load_use_cnt: got load=%0d flush=%0d want 1/0", loadStallCnt, flushCnt);
        else passCnt++;
        checkCnt++;
        if (ctrlVec !== EXP_NOOP) $display("FAIL noop_only_ctrl: got %b want %b", ctrlVec, EXP_NOOP);
        else passCnt++;
        step();
        setIdle();
        #1;
        checkCnt++;
        if (loadStallCnt !== 4'd2) $display("FAIL noop_only_cnt: got %0d want 2", loadStallCnt);
        else passCnt++;
    endtask

    task automatic test_branch();
        for (int i = 0; i < 2; i++) begin
            setIn(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            checkCnt++;
            if (ctrlVec !== EXP_BRANCH)
                $display("FAIL branch_ctrl[%0d]: got %b want %b", i, ctrlVec, EXP_BRANCH);
            else passCnt++;
            step();
            setIdle();
            #1;
            checkCnt++;
            if (ctrlVec !== EXP_RUN) $display("FAIL branch_idle[%0d]: got %b want %b", i, ctrlVec, EXP_RUN);
            else passCnt++;
            step();
        end
        checkCnt++;
        if (flushCnt !== 4'd2) $display("FAIL branch_cnt: got %0d want 2", flushCnt);
        else passCnt++;
    endtask

    task automatic test_mem_wait();
        setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkCnt++;
            if (ctrlVec !== EXP_HOLD) $display("FAIL mem_freeze_ctrl[%0d]: got %b want %b", i, ctrlVec, EXP_HOLD);
            else passCnt++;
            step();
            checkCnt++;
            if (dbgState !== ST_MEM_WAIT)
                $display("FAIL mem_wait_state[%0d]: got %0d want %0d", i, dbgState, ST_MEM_WAIT);
            else passCnt++;
        end
        ack = 1'b1;
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_RUN) $display("FAIL mem_ack_ctrl: got %b want %b", ctrlVec, EXP_RUN);
        else passCnt++;
        step();
        checkCnt++;
        if (dbgState !== ST_RUN || memStallCnt !== 4'd3)
            $display("FAIL mem_ack_after: got state=%0d cnt=%0d want %0d/3", dbgState, memStallCnt, ST_RUN);
        else passCnt++;
        // single-cycle access: request and ack together
        setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_RUN) $display("FAIL single_cycle_ctrl: got %b want %b", ctrlVec, EXP_RUN);
        else passCnt++;
        step();
        setIdle();
        checkCnt++;
        if (dbgState !== ST_RUN || memStallCnt !== 4'd3)
            $display("FAIL single_cycle_after: got state=%0d cnt=%0d want %0d/3", dbgState, memStallCnt, ST_RUN);
        else passCnt++;
    endtask

    task automatic test_freeze_overlap();
        setIn(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checkCnt++;
            if (ctrlVec !== EXP_HOLD) $display("FAIL overlap_freeze[%0d]: got %b want %b", i, ctrlVec, EXP_HOLD);
            else passCnt++;
            step();
        end
        ack = 1'b1;
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_LOAD) $display("FAIL overlap_ack_ctrl: got %b want %b", ctrlVec, EXP_LOAD);
        else passCnt++;
        step();
        setIdle();
        checkCnt++;
        if (memStallCnt !== 4'd5 || loadStallCnt !== 4'd3 || flushCnt !== 4'd2)
            $display("FAIL overlap_cnt: got mem=%0d load=%0d flush=%0d want 5/3/2", memStallCnt, loadStallCnt, flushCnt);
        else passCnt++;
    endtask

    task automatic test_spurious_drop();
        setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        setIdle();
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_RUN) $display("FAIL drop_ctrl: got %b want %b", ctrlVec, EXP_RUN);
        else passCnt++;
        step();
        checkCnt++;
        if (dbgState !== ST_RUN || memStallCnt !== 4'd6)
            $display("FAIL drop_after: got state=%0d cnt=%0d want %0d/6", dbgState, memStallCnt, ST_RUN);
        else passCnt++;
    endtask

    task automatic test_timeout();
        setIn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkCnt++;
            if (ctrlVec !== EXP_HOLD) $display("FAIL timeout_freeze[%0d]: got %b want %b", i, ctrlVec, EXP_HOLD);
            else passCnt++;
            step();
            if (i == 2) begin
                checkCnt++;
                if (dbgState !== ST_MEM_WAIT || timeout !== 1'b0)
                    $display("FAIL timeout_early: got state=%0d timeout=%b want %0d/0", dbgState, timeout, ST_MEM_WAIT);
                else passCnt++;
            end
        end
        checkCnt++;
        if (dbgState !== ST_ERROR || timeout !== 1'b1 || memStallCnt !== 4'd10)
            $display("FAIL timeout_enter: got state=%0d timeout=%b mem=%0d want %0d/1/10", dbgState, timeout, memStallCnt, ST_ERROR);
        else passCnt++;
        setIn(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_HOLD) $display("FAIL error_hold_req: got %b want %b", ctrlVec, EXP_HOLD);
        else passCnt++;
        step();
        setIn(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_HOLD) $display("FAIL error_hold_branch: got %b want %b", ctrlVec, EXP_HOLD);
        else passCnt++;
        step();
        checkCnt++;
        if (dbgState !== ST_ERROR || timeout !== 1'b1 || memStallCnt !== 4'd10 ||
            flushCnt !== 4'd2 || loadStallCnt !== 4'd3)
            $display("FAIL error_sticky: got state=%0d timeout=%b mem=%0d flush=%0d load=%0d want %0d/1/10/2/3",
                     dbgState, timeout, memStallCnt, flushCnt, loadStallCnt, ST_ERROR);
        else passCnt++;
        setIdle();
        rst = 1'b1;
        #1;
        checkCnt++;
        if (ctrlVec !== EXP_RESET) $display("FAIL error_reset_ctrl: got %b want %b", ctrlVec, EXP_RESET);
        else passCnt++;
        step();
        rst = 1'b0;
        #1;
        checkCnt++;
        if (dbgState !== ST_RUN || timeout !== 1'b0 || {loadStallCnt, memStallCnt, flushCnt} !== '0 ||
            ctrlVec !== EXP_RUN)
            $display("FAIL error_recover: got state=%0d timeout=%b cnt=%0d/%0d/%0d ctrl=%b want %0d/0/0/0/0/%b",
                     dbgState, timeout, loadStallCnt, memStallCnt, flushCnt, ctrlVec, ST_RUN, EXP_RUN);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        setIn(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step();
        setIdle();
        #1;
        checkCnt++;
        if (flushCnt !== 4'd1) $display("FAIL flush_wrap: got %0d want 1", flushCnt);
        else passCnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish want finish before 100000");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_freeze_overlap();
        test_spurious_drop();
        test_timeout();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer side of the load-use hazard request.
- Takes the hazard detection unit's noOp/stall/PCWrite requests, the ID-stage branch flush, and the data-memory request/ack handshake.
- Resolves them by priority into per-stage write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Keeps stall/flush performance counters and a memory-wait watchdog. Sits in the CPU top level beside the hazard unit.

Parameters:
- CNT_W, 32, width of each performance counter.
- MAX_WAIT, 255, memory-wait cycles tolerated before a timeout error; must be at least 1.
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- noOpSignal_i  in  1  hazard unit: bubble request for ID/EX
- stallSignal_i  in  1  hazard unit: hold IF/ID
- PCWriteSignal_i  in  1  hazard unit: PC write permission (0 = hold)
- branchFlush_i  in  1  taken branch resolved in ID
- memReq_i  in  1  EX/MEM instruction is accessing data memory (level, held until acked)
- memAck_i  in  1  data memory completes the access this cycle
- pcWrite_o  out  1  PC register enable
- ifidWrite_o  out  1  IF/ID enable
- ifidFlush_o  out  1  IF/ID clear-to-NOP
- idexWrite_o  out  1  ID/EX enable
- idexFlush_o  out  1  ID/EX clear-to-bubble
- exmemWrite_o  out  1  EX/MEM enable
- memwbWrite_o  out  1  MEM/WB enable
- loadStallCnt_o  out  CNT_W  cycles spent on load-use bubbles
- memStallCnt_o  out  CNT_W  cycles spent frozen on memory
- flushCnt_o  out  CNT_W  branch flushes applied
- timeout_o  out  1  sticky memory-wait timeout

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Controls are combinational from the inputs and state, so they act in the same cycle as the request. Counters, state and timeout_o are registered.

Reset:
- While rst_i=1: all *Write_o=0, ifidFlush_o=idexFlush_o=1, counters=0, timeout_o=0, state<=RUN, wait counter=0.

States: RUN, MEM_WAIT, ERROR.

Priority in RUN and MEM_WAIT, highest first:
- (1) Freeze. Condition: memReq_i && !memAck_i. All five write enables=0; both flushes=0. Hazard and branch inputs are ignored.
- (2) Load-use. Condition: noOpSignal_i || stallSignal_i || !PCWriteSignal_i.
  - pcWrite_o = PCWriteSignal_i.
  - ifidWrite_o = !stallSignal_i.
  - idexFlush_o = noOpSignal_i.
  - All other write enables=1. ifidFlush_o=0: branchFlush_i is suppressed because the branch is stalled in ID and will reassert next cycle.
- (3) Branch. Condition: branchFlush_i. ifidFlush_o=1; all write enables=1.
- (4) Normal: all write enables=1; flushes=0.

Transitions:
- RUN -> MEM_WAIT when the freeze condition holds; wait counter <= 1.
- MEM_WAIT:
  - memAck_i=1 -> RUN; wait counter <= 0. The ack cycle is not frozen and evaluates priorities 2-4 normally.
  - memReq_i=0 -> RUN (spurious drop, treated as abort).
  - Otherwise wait counter += 1. When it equals MAX_WAIT with no ack -> ERROR, and timeout_o <= 1.
- ERROR: all write enables=0, flushes=0; held until rst_i. timeout_o stays 1.

Counters:
- Each increments by 1 per qualifying cycle and wraps modulo 2^CNT_W.
- loadStallCnt: +1 on cycles where priority 2 is the applied case.
- memStallCnt: +1 on every frozen cycle, in RUN or MEM_WAIT, excluding ERROR.
- flushCnt: +1 on cycles where ifidFlush_o=1 outside reset.

Other rules:
- memReq_i && memAck_i in the same cycle: the access is single-cycle, no freeze, state stays RUN.
- A reset asserted mid-MEM_WAIT or in ERROR returns to RUN on the next edge.

Decomposition:
- Shared cpu package holds:
  - state enum (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - a control-bundle struct of the seven control outputs;
  - constants for the default MAX_WAIT and CNT_W.
- One natural sub-module: perf_counter, instantiated three times (CNT_W-wide, synchronous clear, enable increment).

Test Plan:
- Reset held 3 cycles, then released with all inputs idle -> during reset all write enables 0 and both flushes 1. After release all enables 1, flushes 0, counters 0.
- Load-use: noOp=1, stall=1, PCWrite=0, branchFlush=1 for one cycle -> pcWrite=0, ifidWrite=0, idexFlush=1, ifidFlush=0. loadStallCnt=1, flushCnt=0.
- Branch alone for 2 separate cycles -> ifidFlush=1 in each, all enables 1. flushCnt=2.
- memReq=1 with ack arriving on the 4th cycle:
  - Cycles 1-3 all enables 0, state MEM_WAIT.
  - Cycle 4 enables 1. memStallCnt=3.
  - Single-cycle req+ack adds 0.
- Freeze overlapping load-use and branch requests -> during freeze all enables 0 and flushes 0. On the ack cycle the load-use response applies.
- MAX_WAIT=4 with memReq held and no ack -> ERROR with timeout_o=1 after the 4th wait cycle. Enables stay 0 while memStallCnt holds. A subsequent rst_i clears everything and returns to RUN.
